silife_load_master: RTL and testbench

- Host-side transmitter for the silife serial load interface.
- Turns parallel requests (command, address, data) into load_cs/load_clk/load_data frames for one silife grid or a daisy chain of them.
- At the same time it shifts in the chain's returned data line, so a host can read back register or cell contents.
- Sits in the controller/harness design, between a CPU-side register block or FIFO and the grid chip's load pins.

---
 rtl/silife_load_master.sv | 133 +++++++++++++
 tb/tb_silife_load_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/silife_load_master.sv
// silife_load_master: host-side serial frame transmitter/receiver for the
// silife load interface. A parallel {cmd, addr, data} request is sent MSB
// first on load_clk/load_data under load_cs. The returned chain data is
// shifted in at the same time, and its low DATA_BITS are presented on o_rdata.
module silife_load_master #(
  parameter int CLK_DIV   = 4,
  parameter int CMD_BITS  = 8,
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [CMD_BITS-1:0]  i_req_cmd,
  input  logic [ADDR_BITS-1:0] i_req_addr,
  input  logic [DATA_BITS-1:0] i_req_data,
  output logic                 o_load_cs,
  output logic                 o_load_clk,
  output logic                 o_load_data,
  input  logic                 i_load_data,
  output logic [DATA_BITS-1:0] o_rdata,
  output logic                 o_done,
  output logic                 o_busy
);

  localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;
  localparam int CW         = $clog2(CLK_DIV + 1);
  localparam int BW         = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS);

  // SETUP is followed by one low phase that does not advance the data, so
  // every rising edge sees a full low phase of stable data before it.
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic [FRAME_BITS-1:0] tx_sh, tx_n;
  logic [DATA_BITS-1:0]  rx_sh, rx_n;
  logic [DATA_BITS-1:0]  rdata_n;
  logic                  done_n, cs_n, lclk_n, ldata_n;
  logic                  phase_end;

  assign o_req_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);

  // Next-state, phase timing and datapath updates.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_cnt;
    tx_n      = tx_sh;
    rx_n      = rx_sh;
    rdata_n   = o_rdata;
    done_n    = 1'b0;
    phase_end = (cnt == '0);
    if (state != IDLE) cnt_n = phase_end ? CNT_LOAD : cnt - CW'(1);

    case (state)
      IDLE: begin
        cnt_n = CNT_LOAD;
        if (i_req_valid) begin
          tx_n    = {i_req_cmd, i_req_addr, i_req_data};
          bit_n   = '0;
          state_n = SETUP;
        end
      end
      SETUP:    if (phase_end) state_n = SHIFT_LO;
      SHIFT_LO: if (phase_end) state_n = SHIFT_HI;
      SHIFT_HI: begin
        if (cnt == CNT_LOAD) rx_n = {rx_sh[DATA_BITS-2:0], i_load_data};
        if (phase_end) begin
          bit_n = bit_cnt + BW'(1);
          if (bit_cnt + BW'(1) == BIT_LAST) begin
            state_n = HOLD;
          end else begin
            // Shift on the same edge that drops load_clk.
            tx_n    = tx_sh << 1;
            state_n = SHIFT_LO;
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          done_n  = 1'b1;
          rdata_n = rx_sh;
          state_n = GAP;
        end
      end
      GAP:     if (phase_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    cs_n    = (state_n == SETUP) || (state_n == SHIFT_LO) ||
              (state_n == SHIFT_HI) || (state_n == HOLD);
    lclk_n  = (state_n == SHIFT_HI);
    ldata_n = cs_n & tx_n[FRAME_BITS-1];
  end

  // State and registered pin drivers; pins are registered to stay glitch-free.
  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: the shift registers are reset along with control so a reset
  // mid-frame leaves no stale receive data behind o_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= CNT_LOAD;
      bit_cnt     <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      o_rdata     <= '0;
      o_done      <= 1'b0;
      o_load_cs   <= 1'b0;
      o_load_clk  <= 1'b0;
      o_load_data <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_cnt     <= bit_n;
      tx_sh       <= tx_n;
      rx_sh       <= rx_n;
      o_rdata     <= rdata_n;
      o_done      <= done_n;
      o_load_cs   <= cs_n;
      o_load_clk  <= lclk_n;
      o_load_data <= ldata_n;
    end
  end

endmodule

// File: tb/tb_silife_load_master.sv
// Testbench for silife_load_master: three instances (CLK_DIV = 4, 1, 7), each
// with a one-bit loopback chain; a scoreboard queue of expected frames is
// checked by per-instance monitors at every o_done.
module tb_silife_load_master;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0] req_valid = '0;
  logic [NI-1:0] req_ready, cs, lclk, ldo, ldi, done, busy;
  logic [7:0]    cmd  = '0;
  logic [23:0]   addr = '0;
  logic [31:0]   data = '0;
  logic [31:0]   rdata [NI];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          inst;
    logic [63:0] frame;
    logic [31:0] rexp;
    int          gap;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 1 : 7);

    // One-bit chain: returned data is o_load_data from one load_clk period ago.
    logic [2*D-1:0] hist = '0;
    always @(posedge clk) hist <= {hist[2*D-2:0], ldo[g]};
    assign ldi[g] = hist[2*D-1];

    silife_load_master #(.CLK_DIV(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .i_req_valid(req_valid[g]),
      .o_req_ready(req_ready[g]),
      .i_req_cmd  (cmd),
      .i_req_addr (addr),
      .i_req_data (data),
      .o_load_cs  (cs[g]),
      .o_load_clk (lclk[g]),
      .o_load_data(ldo[g]),
      .i_load_data(ldi[g]),
      .o_rdata    (rdata[g]),
      .o_done     (done[g]),
      .o_busy     (busy[g])
    );

    int          lat, rises, hi_len, lo_len, gap_len, cs_len, bad_phase, bad_data;
    bit          active, seen_hi, wait_ready;
    logic [63:0] txcap;
    logic [31:0] last_r;
    logic        pcs, pclk, pdata;
    exp_t        e;

    // Monitor: frame timing, serial capture, pin discipline and scoreboard pop.
    always @(negedge clk) begin
      if (reset) begin
        active = 0; wait_ready = 0; rises = 0; gap_len = 0; cs_len = 0;
        pcs = 0; pclk = 0; pdata = 0;
      end else begin
        if (active) lat++;
        if (lclk[g] && !pclk) begin
          rises++;
          txcap = {txcap[62:0], ldo[g]};
          if (seen_hi && lo_len != D) bad_phase++;
          hi_len = 0;
        end
        if (!lclk[g] && pclk) begin
          if (hi_len != D) bad_phase++;
          seen_hi = 1;
          lo_len  = 0;
        end
        if (lclk[g]) hi_len++; else lo_len++;
        if (cs[g] && pcs && (ldo[g] !== pdata) && !(pclk && !lclk[g])) bad_data++;
        if (!cs[g] && ldo[g]) bad_data++;
        if (cs[g] && !pcs) begin
          if (exp_q.size() > 0 && exp_q[0].inst == g && exp_q[0].gap > 0)
            check($sformatf("cs_gap[%0d]", g), gap_len, exp_q[0].gap);
          cs_len = 0;
        end
        if (cs[g]) begin cs_len++; gap_len = 0; end else gap_len++;

        if (done[g]) begin
          if (exp_q.size() == 0 || exp_q[0].inst != g) begin
            checks++; failures++;
            $display("FAIL unexpected_done[%0d]: actual=1 required=0", g);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("tx_bits[%0d]", g), txcap, e.frame);
            check($sformatf("rises[%0d]", g), rises, 64);
            check($sformatf("rdata[%0d]", g), rdata[g], e.rexp);
            check($sformatf("done_lat[%0d]", g), lat, 130 * D + 1);
            check($sformatf("cs_len[%0d]", g), cs_len, 130 * D);
            check($sformatf("phase_len[%0d]", g), bad_phase, 0);
            check($sformatf("data_stable[%0d]", g), bad_data, 0);
            last_r     = e.rexp;
            wait_ready = 1;
          end
        end
        if (wait_ready && req_ready[g]) begin
          check($sformatf("ready_lat[%0d]", g), lat, 131 * D + 1);
          check($sformatf("rdata_hold[%0d]", g), rdata[g], last_r);
          wait_ready = 0;
          active     = 0;
        end
        if (req_valid[g] && req_ready[g]) begin
          active = 1; lat = 0; rises = 0; txcap = '0;
          seen_hi = 0; bad_phase = 0; bad_data = 0;
        end
        pcs = cs[g]; pclk = lclk[g]; pdata = ldo[g];
      end
    end
  end

  // Present a request and return on the clock edge that accepts it; valid
  // stays high so a following send() queues back-to-back.
  task automatic send(input int inst, input logic [7:0] c, input logic [23:0] a,
                      input logic [31:0] d, input int gap);
    exp_t        ex;
    logic [63:0] f;
    bit          ok;
    @(posedge clk); #1;
    cmd = c; addr = a; data = d;
    req_valid = '0;
    req_valid[inst] = 1'b1;
    f  = {c, a, d};
    ex = '{inst: inst, frame: f, rexp: f[32:1], gap: gap};
    exp_q.push_back(ex);
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (req_ready[inst]) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic release_req();
    #1 req_valid = '0;
  endtask

  task automatic wait_idle(input int inst);
    bit ok;
    ok = 0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && req_ready[inst]) begin ok = 1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   r0, dcnt;
    logic pl;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 3'b111);
    check("rst_cs", cs, 0);
    check("rst_lclk", lclk, 0);
    check("rst_ldata", ldo, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata0", rdata[0], 0);
    @(posedge clk); #1 reset = 1'b0;

    // Single write at defaults.
    send(0, 8'h01, 24'h000004, 32'h000000F1, 0); release_req(); wait_idle(0);
    // Loopback readback of a patterned frame.
    send(0, 8'h5A, 24'hC30F99, 32'hA5A51234, 0); release_req(); wait_idle(0);
    // Back-to-back: second accept on first IDLE cycle, cs low CLK_DIV+1.
    send(0, 8'h80, 24'h123456, 32'hDEADBEEF, 0);
    send(0, 8'h7F, 24'hFEDCBA, 32'h00000001, 5);
    release_req(); wait_idle(0);

    // Reset at bit 20 of a frame.
    send(0, 8'h33, 24'h0F0F0F, 32'hFFFF0000, 0); release_req();
    r0 = 0; pl = 0;
    for (int n = 0; n < 2000 && r0 < 20; n++) begin
      @(negedge clk);
      if (lclk[0] && !pl) r0++;
      pl = lclk[0];
    end
    check("reset_bit20_reached", r0, 20);
    @(posedge clk); #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_cs", cs[0], 0);
    check("mid_rst_lclk", lclk[0], 0);
    check("mid_rst_ldata", ldo[0], 0);
    check("mid_rst_ready", req_ready[0], 1);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_rdata", rdata[0], 0);
    reset = 1'b0;
    dcnt = 0;
    repeat (600) begin @(negedge clk); if (done[0]) dcnt++; end
    check("no_done_after_reset", dcnt, 0);
    send(0, 8'hC5, 24'h00ABCD, 32'h13579BDF, 0); release_req(); wait_idle(0);

    // CLK_DIV sweep.
    send(1, 8'h02, 24'h800001, 32'h0F0F0F0F, 0);
    send(1, 8'hAA, 24'h555555, 32'hCAFEF00D, 2);
    release_req(); wait_idle(1);
    send(2, 8'hE1, 24'h3C3C3C, 32'h89ABCDEF, 0); release_req(); wait_idle(2);

    // Random frames with random idle spacing.
    for (int i = 0; i < 40; i++) begin
      send(0, 8'($urandom), 24'($urandom), 32'($urandom), 0);
      release_req();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle(0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
